// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: waits for a stable synchronized PLL lock, then releases
// NUM_RST active-low domain resets in index order; re-sequences on lock loss or software request.
module rst_seq_ctrl #(
   parameter int NUM_RST      = 4,
   parameter int HOLD_CYC     = 16,
   parameter int LOCK_STABLE  = 8,
   parameter int LOCK_TIMEOUT = 1024,
   parameter int STAGE_GAP    = 4,
   parameter int SW_PULSE     = 8,
   parameter int CNT_W        = 16
) (
   input  logic               sys_clk,
   input  logic               rst_temp,
   input  logic               pll_lock,
   input  logic               sw_rst_req,
   output logic [NUM_RST-1:0] rst_n_out,
   output logic               seq_done,
   output logic               timeout_err,
   output logic [2:0]         dbg_state
);

   localparam int IDX_W = $clog2(NUM_RST + 1);

   typedef enum logic [2:0] {
      S_HOLD      = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_RELEASE   = 3'd2,
      S_DONE      = 3'd3,
      S_SWRST     = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   stab_q, stab_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [NUM_RST-1:0] rst_n_q, rst_n_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic               lock_meta_q, lock_meta_d;
   logic               lock_s_q, lock_s_d;
   logic               sw_prev_q, sw_prev_d;
   logic               sw_rise;

   always_comb begin
      lock_meta_d = pll_lock;
      lock_s_d    = lock_meta_q;
      sw_prev_d   = sw_rst_req;
      sw_rise     = sw_rst_req & ~sw_prev_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      stab_d      = stab_q;
      idx_d       = idx_q;
      rst_n_d     = rst_n_q;
      done_d      = done_q;
      err_d       = err_q;
      case (state_q)
         S_HOLD: begin
            rst_n_d = '0;
            done_d  = 1'b0;
            if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
               stab_d  = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WAIT_LOCK: begin
            if (sw_rise) begin
               state_d = S_SWRST;
               cnt_d   = '0;
            end else if (lock_s_q && stab_q == CNT_W'(LOCK_STABLE - 1)) begin
               state_d = S_RELEASE;
               cnt_d   = '0;
               idx_d   = '0;
            end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
               state_d = S_HOLD;
               cnt_d   = '0;
               err_d   = 1'b1;
            end else begin
               cnt_d  = cnt_q + CNT_W'(1);
               stab_d = lock_s_q ? stab_q + CNT_W'(1) : '0;
            end
         end
         S_RELEASE: begin
            // Lock loss takes priority over a coincident software request.
            if (!lock_s_q) begin
               state_d = S_HOLD;
               cnt_d   = '0;
               rst_n_d = '0;
               done_d  = 1'b0;
            end else if (sw_rise) begin
               state_d = S_SWRST;
               cnt_d   = '0;
               rst_n_d = '0;
               done_d  = 1'b0;
            end else if (idx_q == IDX_W'(NUM_RST)) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
               for (int i = 0; i < NUM_RST; i++) begin
                  if (idx_q == IDX_W'(i)) rst_n_d[i] = 1'b1;
               end
               cnt_d = '0;
               idx_d = idx_q + IDX_W'(1);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            if (!lock_s_q) begin
               state_d = S_HOLD;
               cnt_d   = '0;
               rst_n_d = '0;
               done_d  = 1'b0;
            end else if (sw_rise) begin
               state_d = S_SWRST;
               cnt_d   = '0;
               rst_n_d = '0;
               done_d  = 1'b0;
            end
         end
         S_SWRST: begin
            rst_n_d = '0;
            done_d  = 1'b0;
            if (cnt_q == CNT_W'(SW_PULSE - 1)) begin
               state_d = S_HOLD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_HOLD;
            cnt_d   = '0;
            rst_n_d = '0;
            done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge rst_temp) begin
      if (!rst_temp) begin
         state_q     <= S_HOLD;
         cnt_q       <= '0;
         stab_q      <= '0;
         idx_q       <= '0;
         rst_n_q     <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
         sw_prev_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stab_q      <= stab_d;
         idx_q       <= idx_d;
         rst_n_q     <= rst_n_d;
         done_q      <= done_d;
         err_q       <= err_d;
         lock_meta_q <= lock_meta_d;
         lock_s_q    <= lock_s_d;
         sw_prev_q   <= sw_prev_d;
      end
   end

   assign rst_n_out   = rst_n_q;
   assign seq_done    = done_q;
   assign timeout_err = err_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: cycle numbers count rising edges after rst_temp release,
// and outputs are sampled on the falling edge that follows each counted rising edge.
module tb_rst_seq_ctrl;

   localparam logic [2:0] ST_HOLD    = 3'd0;
   localparam logic [2:0] ST_WAIT    = 3'd1;
   localparam logic [2:0] ST_RELEASE = 3'd2;
   localparam logic [2:0] ST_DONE    = 3'd3;
   localparam logic [2:0] ST_SWRST   = 3'd4;

   logic       sys_clk = 1'b0;
   logic       rst_temp = 1'b0;
   logic       pll_lock = 1'b0;
   logic       sw_rst_req = 1'b0;
   logic [3:0] rst_n_out;
   logic       seq_done;
   logic       timeout_err;
   logic [2:0] dbg_state;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   rst_seq_ctrl dut (
      .sys_clk    (sys_clk),
      .rst_temp   (rst_temp),
      .pll_lock   (pll_lock),
      .sw_rst_req (sw_rst_req),
      .rst_n_out  (rst_n_out),
      .seq_done   (seq_done),
      .timeout_err(timeout_err),
      .dbg_state  (dbg_state)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic tick_to(input int k);
      while (cyc < k) begin
         @(negedge sys_clk);
         cyc++;
      end
   endtask

   task automatic check_outs(input string tag, input logic [3:0] rst_exp,
                             input logic done_exp, input logic err_exp);
      check_eq({tag, ".rst_n"}, 32'(rst_n_out), 32'(rst_exp));
      check_eq({tag, ".done"},  32'(seq_done),  32'(done_exp));
      check_eq({tag, ".err"},   32'(timeout_err), 32'(err_exp));
   endtask

   task automatic do_reset(input logic lock_val);
      rst_temp = 1'b0;
      pll_lock = lock_val;
      sw_rst_req = 1'b0;
      repeat (3) @(negedge sys_clk);
      check_outs("reset", 4'h0, 1'b0, 1'b0);
      check_eq("reset.state", 32'(dbg_state), 32'(ST_HOLD));
      rst_temp = 1'b1;
      cyc = 0;
   endtask

   initial begin
      // Power-up with lock held high; a request in HOLD must be ignored.
      do_reset(1'b1);
      tick_to(5);  sw_rst_req = 1'b1;
      tick_to(6);  check_eq("hold_sw_ignored", 32'(dbg_state), 32'(ST_HOLD));
      sw_rst_req = 1'b0;
      tick_to(15); check_eq("hold_end", 32'(dbg_state), 32'(ST_HOLD));
      tick_to(16); check_eq("wait_entry", 32'(dbg_state), 32'(ST_WAIT));
      tick_to(23); check_eq("wait_end", 32'(dbg_state), 32'(ST_WAIT));
      tick_to(24); check_eq("release_entry", 32'(dbg_state), 32'(ST_RELEASE));
      tick_to(27); check_outs("pre_bit0", 4'h0, 1'b0, 1'b0);
      tick_to(28); check_outs("bit0", 4'h1, 1'b0, 1'b0);
      tick_to(31); check_outs("hold_bit0", 4'h1, 1'b0, 1'b0);
      tick_to(32); check_outs("bit1", 4'h3, 1'b0, 1'b0);
      tick_to(36); check_outs("bit2", 4'h7, 1'b0, 1'b0);
      tick_to(40); check_outs("bit3", 4'hf, 1'b0, 1'b0);
      tick_to(41); check_outs("done", 4'hf, 1'b1, 1'b0);
      check_eq("done.state", 32'(dbg_state), 32'(ST_DONE));

      // Software pulse from DONE, then a full re-sequence.
      tick_to(45); sw_rst_req = 1'b1;
      tick_to(46); check_outs("sw_entry", 4'h0, 1'b0, 1'b0);
      check_eq("sw.state", 32'(dbg_state), 32'(ST_SWRST));
      sw_rst_req = 1'b0;
      tick_to(53); check_eq("sw_last", 32'(dbg_state), 32'(ST_SWRST));
      check_eq("sw_last.rst_n", 32'(rst_n_out), 32'h0);
      tick_to(54); check_eq("sw_to_hold", 32'(dbg_state), 32'(ST_HOLD));
      tick_to(81); check_eq("sw_reseq.state", 32'(dbg_state), 32'(ST_RELEASE));
      check_eq("sw_reseq.pre", 32'(rst_n_out), 32'h0);
      tick_to(82); check_eq("sw_reseq.bit0", 32'(rst_n_out), 32'h1);
      tick_to(95); check_outs("sw_reseq.done", 4'hf, 1'b1, 1'b0);

      // Lock glitch of 3 cycles inside the stability window.
      do_reset(1'b1);
      tick_to(18); pll_lock = 1'b0;
      tick_to(21); pll_lock = 1'b1;
      tick_to(30); check_eq("glitch.wait", 32'(dbg_state), 32'(ST_WAIT));
      tick_to(31); check_eq("glitch.release", 32'(dbg_state), 32'(ST_RELEASE));
      tick_to(34); check_eq("glitch.pre_bit0", 32'(rst_n_out), 32'h0);
      tick_to(35); check_eq("glitch.bit0", 32'(rst_n_out), 32'h1);

      // Lock loss after bit 1 with a coincident software request.
      do_reset(1'b1);
      tick_to(32); check_eq("loss.bit1", 32'(rst_n_out), 32'h3);
      pll_lock = 1'b0;
      tick_to(34); check_eq("loss.pre", 32'(rst_n_out), 32'h3);
      sw_rst_req = 1'b1;
      tick_to(35); check_outs("loss", 4'h0, 1'b0, 1'b0);
      check_eq("loss.state", 32'(dbg_state), 32'(ST_HOLD));
      sw_rst_req = 1'b0;
      tick_to(36); check_eq("loss.stay_hold", 32'(dbg_state), 32'(ST_HOLD));

      // Lock never arrives: timeout, retry, then lock comes and err stays set.
      do_reset(1'b0);
      tick_to(1039); check_outs("pre_timeout", 4'h0, 1'b0, 1'b0);
      check_eq("pre_timeout.state", 32'(dbg_state), 32'(ST_WAIT));
      tick_to(1040); check_outs("timeout", 4'h0, 1'b0, 1'b1);
      check_eq("timeout.state", 32'(dbg_state), 32'(ST_HOLD));
      pll_lock = 1'b1;
      tick_to(1063); check_eq("retry.wait", 32'(dbg_state), 32'(ST_WAIT));
      tick_to(1064); check_eq("retry.release", 32'(dbg_state), 32'(ST_RELEASE));
      tick_to(1068); check_outs("retry.bit0", 4'h1, 1'b0, 1'b1);
      tick_to(1074); check_outs("retry.bit1", 4'h3, 1'b0, 1'b1);

      // Asynchronous rst_temp mid-sequence clears everything, including err.
      rst_temp = 1'b0;
      #1;
      check_outs("async_rst", 4'h0, 1'b0, 1'b0);
      check_eq("async_rst.state", 32'(dbg_state), 32'(ST_HOLD));
      do_reset(1'b1);
      tick_to(27); check_eq("restart.pre_bit0", 32'(rst_n_out), 32'h0);
      tick_to(28); check_outs("restart.bit0", 4'h1, 1'b0, 1'b0);
      tick_to(41); check_outs("restart.done", 4'hf, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
